// File: rtl/note_game_pkg.sv
// Shared types, field widths and crossing helpers for the note-wall game.
package note_game_pkg;

  localparam int X_W    = 13;
  localparam int NOTE_W = 16;
  localparam int GAP_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    MOVE     = 2'd1,
    BOUNCE   = 2'd2
  } wall_state_t;

  // True when a wall moving left by 'speed' this frame sweeps over ball_x.
  function automatic logic wall_crosses(input logic [X_W-1:0] x,
                                        input logic [10:0] ball_x,
                                        input logic [2:0] speed);
    logic [X_W-1:0] bx;
    bx = {2'b00, ball_x};
    return (x >= bx) && (x < (bx + X_W'(speed)));
  endfunction

  // Pass window [max(gap-margin,0), gap+height] in 11-bit unsigned, no wrap.
  function automatic logic in_pass_window(input logic [9:0] ball_y,
                                          input logic [GAP_W-1:0] gap_y,
                                          input int margin,
                                          input int height);
    logic [10:0] g;
    logic [10:0] y;
    logic [10:0] lo;
    logic [10:0] hi;
    g  = {2'b00, gap_y};
    y  = {1'b0, ball_y};
    lo = (g >= 11'(margin)) ? (g - 11'(margin)) : 11'd0;
    hi = g + 11'(height);
    return (y >= lo) && (y <= hi);
  endfunction

endpackage

// File: rtl/wall_slot.sv
// One wall slot: position, note, motion state and bounce offset.
// Pass/hit/retire flags are combinational and valid in the frame-step cycle.
module wall_slot
  import note_game_pkg::*;
#(
  parameter int SCREEN_WIDTH = 1280,
  parameter int GAP_MARGIN   = 5,
  parameter int GAP_HEIGHT   = 45,
  parameter int MAX_BOUNCE   = 16,
  parameter int BOUNCE_DECAY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic              i_spawn,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [2:0]        i_speed,
  input  logic [10:0]       i_ball_x,
  input  logic [9:0]        i_ball_y,
  input  logic [GAP_W-1:0]  i_gap_y,
  output logic [X_W-1:0]    o_x,
  output logic [NOTE_W-1:0] o_note,
  output wall_state_t       o_state,
  output logic              o_pass,
  output logic              o_hit,
  output logic              o_retire
);

  localparam int OFF_W = 5;
  localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_WIDTH);

  logic [X_W-1:0]    r_x;
  logic [NOTE_W-1:0] r_note;
  wall_state_t       r_state;
  logic [OFF_W-1:0]  r_off;
  logic              w_cross;
  logic              w_window;

  // Crossing and pass-window evaluation; only a moving wall can score or hit.
  always_comb begin
    w_cross  = (r_state == MOVE) && wall_crosses(r_x, i_ball_x, i_speed);
    w_window = in_pass_window(i_ball_y, i_gap_y, GAP_MARGIN, GAP_HEIGHT);
    o_pass   = i_step && w_cross && w_window;
    o_hit    = i_step && w_cross && !w_window;
    o_retire = i_step && (r_state == MOVE) && !(w_cross && !w_window) &&
               (r_x < X_W'(i_speed));
  end

  // Slot state update: clear on game restart, otherwise advance once per frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x     <= SPAWN_X;
      r_note  <= '0;
      r_state <= INACTIVE;
      r_off   <= '0;
    end else if (i_clear) begin
      r_x     <= SPAWN_X;
      r_state <= INACTIVE;
      r_off   <= '0;
    end else if (i_step) begin
      case (r_state)
        INACTIVE: begin
          if (i_spawn) begin
            r_x     <= SPAWN_X;
            r_note  <= i_note;
            r_state <= MOVE;
          end
        end
        MOVE: begin
          if (o_hit) begin
            r_state <= BOUNCE;
            r_off   <= OFF_W'(MAX_BOUNCE);
          end else if (o_retire) begin
            r_state <= INACTIVE;
            r_x     <= SPAWN_X;
          end else begin
            r_x <= r_x - X_W'(i_speed);
          end
        end
        BOUNCE: begin
          if (r_off != '0) begin
            r_x   <= r_x + X_W'(r_off);
            r_off <= (r_off > OFF_W'(BOUNCE_DECAY)) ? (r_off - OFF_W'(BOUNCE_DECAY)) : '0;
          end else begin
            r_state <= MOVE;
          end
        end
        default: r_state <= INACTIVE;
      endcase
    end
  end

  assign o_x     = r_x;
  assign o_note  = r_note;
  assign o_state = r_state;

endmodule

// File: rtl/wall_scheduler.sv
// Note-wall game controller: game FSM, one-entry note buffer, spawn arbiter,
// score and lives around WALL_COUNT wall_slot instances.
// Optional: define WALL_SPEEDUP_EN for wall speed rising every 8 passes.
// Note intake handshake: a note transfers on a cycle where note_valid_in and
// note_ready_out are both high; ready is low exactly while the buffer holds a note.
module wall_scheduler
  import note_game_pkg::*;
#(
  parameter int WALL_COUNT   = 3,
  parameter int SCREEN_WIDTH = 1280,
  parameter int MIN_SPACING  = 320,
  parameter int GAP_MARGIN   = 5,
  parameter int GAP_HEIGHT   = 45,
  parameter int MAX_BOUNCE   = 16,
  parameter int BOUNCE_DECAY = 2,
  parameter int START_LIVES  = 3
) (
  input  logic                         pixel_clk_in,
  input  logic                         rst_in,
  input  logic                         nf_in,
  input  logic                         start_in,
  input  logic                         note_valid_in,
  input  logic [NOTE_W-1:0]            note_in,
  output logic                         note_ready_out,
  input  logic [10:0]                  ball_x_in,
  input  logic [9:0]                   ball_y_in,
  input  logic [GAP_W*WALL_COUNT-1:0]  gap_y_in,
  output logic [X_W*WALL_COUNT-1:0]    wall_x_out,
  output logic [NOTE_W*WALL_COUNT-1:0] wall_note_out,
  output logic [WALL_COUNT-1:0]        wall_active_out,
  output logic [1:0]                   state_out,
  output logic [15:0]                  score_out,
  output logic [3:0]                   lives_out,
  output logic                         hit_out
);

  localparam int IW = (WALL_COUNT > 1) ? $clog2(WALL_COUNT) : 1;
  localparam logic [X_W-1:0] SPAWN_LIMIT = X_W'(SCREEN_WIDTH - MIN_SPACING);

  game_state_t       r_state;
  game_state_t       w_state_next;
  logic              r_start_d;
  logic              r_buf_valid;
  logic [NOTE_W-1:0] r_buf;
  logic [IW-1:0]     r_newest;
  logic [15:0]       r_score;
  logic [3:0]        r_lives;
  logic              r_hit;

  logic              w_step;
  logic              w_clear;
  logic              w_start_play;
  logic [2:0]        w_speed;
  logic [WALL_COUNT-1:0] w_pass_vec;
  logic [WALL_COUNT-1:0] w_hit_vec;
  logic [WALL_COUNT-1:0] w_retire_vec;
  logic [WALL_COUNT-1:0] w_spawn_vec;
  wall_state_t       w_wstate [WALL_COUNT];
  logic [X_W-1:0]    w_x      [WALL_COUNT];
  logic [NOTE_W-1:0] w_note   [WALL_COUNT];
  logic              w_free_found;
  logic [IW-1:0]     w_free_idx;
  logic              w_any_active;
  logic              w_spawn_ok;
  logic [3:0]        w_hits;
  logic [3:0]        w_passes;
  logic [3:0]        w_lives_dec;
  logic [16:0]       w_score_sum;

  assign w_step       = nf_in && (r_state == PLAY);
  assign w_clear      = (r_state == OVER) && start_in && !r_start_d;
  assign w_start_play = (r_state == IDLE) && start_in;

  // Hit/pass counts and lowest-index free slot; a retiring slot is never free.
  always_comb begin
    w_hits       = '0;
    w_passes     = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_any_active = 1'b0;
    for (int i = 0; i < WALL_COUNT; i++) begin
      w_hits   = w_hits + {3'b000, w_hit_vec[i]};
      w_passes = w_passes + {3'b000, w_pass_vec[i]};
      if (w_wstate[i] != INACTIVE) begin
        w_any_active = 1'b1;
      end else if (!w_free_found && !w_retire_vec[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  // Spawn arbitration: one new wall per frame, spaced behind the newest one.
  always_comb begin
    w_spawn_ok = w_step && r_buf_valid && w_free_found &&
                 (!w_any_active || (w_x[r_newest] <= SPAWN_LIMIT));
    for (int i = 0; i < WALL_COUNT; i++) begin
      w_spawn_vec[i] = w_spawn_ok && (w_free_idx == IW'(i));
    end
  end

  assign w_lives_dec = (r_lives > w_hits) ? (r_lives - w_hits) : 4'd0;
  assign w_score_sum = {1'b0, r_score} + {13'b0, w_passes};

  // Game FSM state register.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Game FSM next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_next = PLAY;
      PLAY:    if (w_step && (w_lives_dec == 4'd0)) w_state_next = OVER;
      OVER:    if (w_clear) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Start edge detector, note buffer and newest-wall tracker.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_start_d   <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
      r_newest    <= '0;
    end else begin
      r_start_d <= start_in;
      if (w_spawn_ok) begin
        r_buf_valid <= 1'b0;
        r_newest    <= w_free_idx;
      end else if (note_valid_in && !r_buf_valid) begin
        r_buf_valid <= 1'b1;
        r_buf       <= note_in;
      end
    end
  end

  // Score, lives and the collision pulse.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_score <= '0;
      r_lives <= 4'(START_LIVES);
      r_hit   <= 1'b0;
    end else begin
      r_hit <= w_step && (w_hits != 4'd0);
      if (w_start_play) begin
        r_score <= '0;
        r_lives <= 4'(START_LIVES);
      end else if (w_step) begin
        r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        r_lives <= w_lives_dec;
      end
    end
  end

`ifdef WALL_SPEEDUP_EN
  logic [2:0] r_speed;
  logic [2:0] r_pass_cnt;
  logic [3:0] w_pass_cnt_sum;
  assign w_pass_cnt_sum = {1'b0, r_pass_cnt} + w_passes;

  // Speed ramps after every 8 passes, capped at 4, back to 1 on a new game.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_speed    <= 3'd1;
      r_pass_cnt <= '0;
    end else if (w_start_play) begin
      r_speed    <= 3'd1;
      r_pass_cnt <= '0;
    end else if (w_step) begin
      r_pass_cnt <= w_pass_cnt_sum[2:0];
      if (w_pass_cnt_sum[3] && (r_speed < 3'd4)) r_speed <= r_speed + 3'd1;
    end
  end
  assign w_speed = r_speed;
`else
  assign w_speed = 3'd1;
`endif

  for (genvar g = 0; g < WALL_COUNT; g++) begin : g_slot
    wall_slot #(
      .SCREEN_WIDTH (SCREEN_WIDTH),
      .GAP_MARGIN   (GAP_MARGIN),
      .GAP_HEIGHT   (GAP_HEIGHT),
      .MAX_BOUNCE   (MAX_BOUNCE),
      .BOUNCE_DECAY (BOUNCE_DECAY)
    ) u_slot (
      .i_clk    (pixel_clk_in),
      .i_rst    (rst_in),
      .i_step   (w_step),
      .i_clear  (w_clear),
      .i_spawn  (w_spawn_vec[g]),
      .i_note   (r_buf),
      .i_speed  (w_speed),
      .i_ball_x (ball_x_in),
      .i_ball_y (ball_y_in),
      .i_gap_y  (gap_y_in[g*GAP_W +: GAP_W]),
      .o_x      (w_x[g]),
      .o_note   (w_note[g]),
      .o_state  (w_wstate[g]),
      .o_pass   (w_pass_vec[g]),
      .o_hit    (w_hit_vec[g]),
      .o_retire (w_retire_vec[g])
    );
    assign wall_x_out[g*X_W +: X_W]          = w_x[g];
    assign wall_note_out[g*NOTE_W +: NOTE_W] = w_note[g];
    assign wall_active_out[g]                = (w_wstate[g] != INACTIVE);
  end

  assign note_ready_out = !r_buf_valid;
  assign state_out      = r_state;
  assign score_out      = r_score;
  assign lives_out      = r_lives;
  assign hit_out        = r_hit;

endmodule

// File: tb/tb_wall_scheduler.sv
// Self-checking bench for wall_scheduler (default build, speed 1).
module tb_wall_scheduler;

  localparam int WC = 3;

  logic clk;
  logic rst;
  logic nf;
  logic start;
  logic nv;
  logic [15:0] note;
  logic ready;
  logic [10:0] bx;
  logic [9:0] by;
  logic [8:0] gy [WC];
  logic [9*WC-1:0] gap_bus;
  logic [13*WC-1:0] wx;
  logic [16*WC-1:0] wn;
  logic [WC-1:0] wa;
  logic [1:0] st;
  logic [15:0] score;
  logic [3:0] lives;
  logic hit;

  int n_checks;
  int n_errors;
  bit stream;
  bit saw_hit;

  // Reference model of the game at frame/event level.
  int m_state, m_score, m_lives, m_buf, m_newest;
  bit m_bv, m_hit, m_start_d;
  int m_x [WC];
  int m_note [WC];
  int m_st [WC];
  int m_off [WC];

  wall_scheduler dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst),
    .nf_in           (nf),
    .start_in        (start),
    .note_valid_in   (nv),
    .note_in         (note),
    .note_ready_out  (ready),
    .ball_x_in       (bx),
    .ball_y_in       (by),
    .gap_y_in        (gap_bus),
    .wall_x_out      (wx),
    .wall_note_out   (wn),
    .wall_active_out (wa),
    .state_out       (st),
    .score_out       (score),
    .lives_out       (lives),
    .hit_out         (hit)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always_comb begin
    for (int i = 0; i < WC; i++) gap_bus[i*9 +: 9] = gy[i];
  end

  function automatic int slot_x(input int i);
    return int'(wx[i*13 +: 13]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 3; m_buf = 0; m_newest = 0;
    m_bv = 0; m_hit = 0; m_start_d = 0;
    for (int i = 0; i < WC; i++) begin
      m_x[i] = 1280; m_note[i] = 0; m_st[i] = 0; m_off[i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_cycle();
    int hits, passes, free, lo, hi;
    bit any, ok, step, clear, pre_bv;
    pre_bv = m_bv;
    step = nf && (m_state == 1);
    clear = (m_state == 2) && start && !m_start_d;
    m_hit = 0;
    if (step) begin
      any = 0; free = -1;
      for (int i = 0; i < WC; i++) begin
        if (m_st[i] != 0) any = 1;
        else if (free < 0) free = i;
      end
      ok = m_bv && (free >= 0) && (!any || m_x[m_newest] <= 1280 - 320);
      hits = 0; passes = 0;
      for (int i = 0; i < WC; i++) begin
        if (m_st[i] == 1) begin
          if (m_x[i] == int'(bx)) begin
            lo = int'(gy[i]) - 5;
            if (lo < 0) lo = 0;
            hi = int'(gy[i]) + 45;
            if (int'(by) >= lo && int'(by) <= hi) passes++;
            else begin hits++; m_st[i] = 2; m_off[i] = 16; end
          end
          if (m_st[i] == 1) begin
            if (m_x[i] == 0) begin m_st[i] = 0; m_x[i] = 1280; end
            else m_x[i] = m_x[i] - 1;
          end
        end else if (m_st[i] == 2) begin
          if (m_off[i] > 0) begin
            m_x[i] = m_x[i] + m_off[i];
            m_off[i] = (m_off[i] > 2) ? m_off[i] - 2 : 0;
          end else m_st[i] = 1;
        end
      end
      if (ok) begin
        m_x[free] = 1280; m_note[free] = m_buf; m_st[free] = 1;
        m_bv = 0; m_newest = free;
      end
      m_score = (m_score + passes > 65535) ? 65535 : m_score + passes;
      m_lives = (m_lives > hits) ? m_lives - hits : 0;
      m_hit = (hits > 0);
      if (m_lives == 0) m_state = 2;
    end else if (m_state == 0 && start) begin
      m_state = 1; m_score = 0; m_lives = 3;
    end else if (clear) begin
      m_state = 0;
      for (int i = 0; i < WC; i++) begin m_st[i] = 0; m_x[i] = 1280; end
    end
    if (nv && !pre_bv) begin m_bv = 1; m_buf = int'(note); end
    m_start_d = start;
  endtask

  task automatic compare_all();
    check("state", st, m_state);
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("hit", hit, m_hit);
    check("ready", ready, !m_bv);
    for (int i = 0; i < WC; i++) begin
      check($sformatf("x%0d", i), wx[i*13 +: 13], m_x[i]);
      check($sformatf("note%0d", i), wn[i*16 +: 16], m_note[i]);
      check($sformatf("active%0d", i), wa[i], m_st[i] != 0);
    end
  endtask

  // Driver: one clock with model update and full comparison.
  task automatic step_cycle();
    if (stream) begin nv = 1'b1; note = 16'($urandom); end
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic frame();
    nf = 1'b1;
    step_cycle();
    nf = 1'b0;
    saw_hit = (hit === 1'b1);
    step_cycle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, st, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_score"}, score, 0);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_active"}, wa, 0);
    for (int i = 0; i < WC; i++) begin
      check($sformatf("%s_x%0d", tag, i), wx[i*13 +: 13], 1280);
      check($sformatf("%s_note%0d", tag, i), wn[i*16 +: 16], 0);
    end
  endtask

  initial begin
    int n, prev, base;
    int frozen [WC];
    n_checks = 0; n_errors = 0; stream = 0; saw_hit = 0;
    rst = 1'b1; nf = 0; start = 0; nv = 0; note = 0; bx = 11'd200; by = 10'd120;
    for (int i = 0; i < WC; i++) gy[i] = 9'd100;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b0;

    // Note handshake in IDLE.
    nv = 1'b1; note = 16'h1234;
    step_cycle();
    nv = 1'b0;
    check("ready_after_capture", ready, 0);
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    check("play", st, 1);
    frame();
    check("spawn0_x", slot_x(0), 1280);
    check("spawn0_note", wn[15:0], 16'h1234);
    check("spawn0_active", wa[0], 1);
    check("spawn0_ready", ready, 1);

    // Continuous stream: spacing-limited spawns.
    stream = 1;
    n = 0; prev = slot_x(0);
    while (!wa[1] && n < 400) begin prev = slot_x(0); frame(); n++; end
    check("spawn1_seen", wa[1], 1);
    check("spawn1_prev_x0", prev, 960);
    n = 0; prev = slot_x(1);
    while (!wa[2] && n < 400) begin prev = slot_x(1); frame(); n++; end
    check("spawn2_seen", wa[2], 1);
    check("spawn2_prev_x1", prev, 960);

    // Pass at ball_y = gap+20.
    n = 0;
    while (score == 0 && n < 1200) begin frame(); n++; end
    check("pass_score", score, 1);
    check("pass_lives", lives, 3);

    // Hit at ball_y = gap+60, then bounce sequence on slot1.
    by = 10'd160;
    n = 0; saw_hit = 0;
    while (!saw_hit && n < 1200) begin frame(); n++; end
    check("hit_seen", saw_hit, 1);
    check("hit_lives", lives, 2);
    base = slot_x(1);
    check("hit_x1", base, 200);
    prev = base;
    for (int k = 0; k < 8; k++) begin
      frame();
      check($sformatf("bounce%0d", k), slot_x(1), prev + 16 - 2 * k);
      prev = slot_x(1);
    end
    check("bounce_total", prev - base, 72);
    frame();
    check("bounce_end_hold", slot_x(1), prev);
    frame();
    check("move_resume", slot_x(1), prev - 1);

    // Clamp at the top of the pass window: gap_y=2, ball_y=0 passes.
    for (int i = 0; i < WC; i++) gy[i] = 9'd2;
    by = 10'd0;
    n = 0;
    while (score < 3 && n < 1500) begin frame(); n++; end
    check("clamp_score", score, 3);
    check("clamp_lives", lives, 2);

    // Run out of lives, then freeze and restart.
    by = 10'd300;
    n = 0;
    while (st != 2'd2 && n < 3000) begin frame(); n++; end
    check("over_state", st, 2);
    check("over_lives", lives, 0);
    for (int i = 0; i < WC; i++) frozen[i] = slot_x(i);
    repeat (5) frame();
    for (int i = 0; i < WC; i++) check($sformatf("frozen%0d", i), slot_x(i), frozen[i]);
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    check("restart_idle", st, 0);
    check("restart_inactive", wa, 0);
    for (int i = 0; i < WC; i++) check($sformatf("restart_x%0d", i), slot_x(i), 1280);
    step_cycle();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    check("replay_state", st, 1);
    check("replay_lives", lives, 3);

    // Asynchronous reset during a bounce.
    n = 0; saw_hit = 0;
    while (!saw_hit && n < 1500) begin frame(); n++; end
    check("rst_hit_seen", saw_hit, 1);
    frame();
    frame();
    check("rst_bouncing", ready, 0);
    stream = 0; nv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized play against the model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        bx = 11'($urandom_range(0, 1300));
        for (int i = 0; i < WC; i++) gy[i] = 9'($urandom_range(0, 400));
      end
      nf = ($urandom_range(0, 1) == 0);
      nv = ($urandom_range(0, 3) != 0);
      note = 16'($urandom);
      start = ($urandom_range(0, 40) == 0);
      by = 10'($urandom_range(0, 500));
      step_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
